// File: rtl/adder_frame_accumulator_pkg.sv
// Shared definitions for the frame accumulator: operand/sum widths and FSM state encoding.
package adder_frame_accumulator_pkg;

  localparam int ADD_W = 11;
  localparam int SUM_W = 12;

  typedef enum logic {
    ST_ACC  = 1'b0,
    ST_DONE = 1'b1
  } state_t;

endpackage

// File: rtl/adder_11bit.sv
// Existing 11-bit adder stage: unsigned a+b with carry-in tied low, 12-bit sum.
module adder_11bit
  import adder_frame_accumulator_pkg::*;
(
  input  logic [ADD_W-1:0] a,
  input  logic [ADD_W-1:0] b,
  output logic [SUM_W-1:0] sum
);

  logic cin;

  assign cin = 1'b0;

  // Full-width add; the carry out lands in sum[SUM_W-1].
  always_comb begin
    sum = {1'b0, a} + {1'b0, b} + {{(SUM_W-1){1'b0}}, cin};
  end

endmodule

// File: rtl/adder_frame_accumulator.sv
// Frame accumulator: registers operand pairs, sums them through adder_11bit and
// accumulates the 12-bit results over a frame, then holds one frame total for a
// valid/ready consumer.
//
// state   | meaning
// --------+---------------------------------------------------------------
// ST_ACC  | collecting operand pairs; in_ready high unless the closing pair
//         | is still in stage 1
// ST_DONE | frame total presented on out_*; waiting for out_ready
module adder_frame_accumulator
  import adder_frame_accumulator_pkg::*;
#(
  parameter  int FRAME_LEN = 16,
  parameter  int ACC_W     = 16,
  localparam int CNT_W     = $clog2(FRAME_LEN + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [10:0]      in_a,
  input  logic [10:0]      in_b,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic [CNT_W-1:0] out_count,
  output logic             out_overflow
);

  state_t state;
  state_t state_nxt;

  logic [ADD_W-1:0] op_a;
  logic [ADD_W-1:0] op_b;
  logic             p1_valid;
  logic             p1_last;
  logic [CNT_W-1:0] cnt;

  logic [ACC_W-1:0] acc;
  logic             ovf;

  logic [SUM_W-1:0] pair_sum;
  logic [ACC_W:0]   acc_tot;
  logic             accept;
  logic             close;
  logic             release_out;
  logic             cnt_at_last;

  adder_11bit u_adder (
    .a   (op_a),
    .b   (op_b),
    .sum (pair_sum)
  );

  assign accept      = in_valid && in_ready;
  assign close       = p1_valid && p1_last;
  assign cnt_at_last = (cnt == CNT_W'(FRAME_LEN - 1));

  // The only accumulate adder: extra top bit captures the carry beyond ACC_W.
  always_comb begin
    acc_tot = {1'b0, acc} + {{(ACC_W + 1 - SUM_W){1'b0}}, pair_sum};
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_ACC;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and handshake outputs; input blocked while the closing pair drains.
  always_comb begin
    state_nxt   = state;
    in_ready    = 1'b0;
    release_out = 1'b0;
    case (state)
      ST_ACC: begin
        in_ready = !(p1_valid && p1_last);
        if (close) begin
          state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_valid && out_ready) begin
          release_out = 1'b1;
          state_nxt   = ST_ACC;
        end
      end
      default: begin
        state_nxt = ST_ACC;
      end
    endcase
  end

  // Stage 1: capture the accepted pair and decide whether it closes the frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_a     <= '0;
      op_b     <= '0;
      p1_valid <= 1'b0;
      p1_last  <= 1'b0;
      cnt      <= '0;
    end else begin
      if (accept) begin
        op_a     <= in_a;
        op_b     <= in_b;
        p1_valid <= 1'b1;
        p1_last  <= in_last || cnt_at_last;
        cnt      <= cnt + CNT_W'(1);
      end else begin
        p1_valid <= 1'b0;
      end
      if (release_out) begin
        cnt <= '0;
      end
    end
  end

  // Stage 2: accumulate, publish the total on the closing pair, clear on handoff.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc          <= '0;
      ovf          <= 1'b0;
      out_valid    <= 1'b0;
      out_sum      <= '0;
      out_count    <= '0;
      out_overflow <= 1'b0;
    end else begin
      if (p1_valid) begin
        acc <= acc_tot[ACC_W-1:0];
        ovf <= ovf | acc_tot[ACC_W];
      end
      if (close) begin
        out_valid    <= 1'b1;
        out_sum      <= acc_tot[ACC_W-1:0];
        out_count    <= cnt;
        out_overflow <= ovf | acc_tot[ACC_W];
      end else if (release_out) begin
        out_valid <= 1'b0;
        acc       <= '0;
        ovf       <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_adder_frame_accumulator.sv
// Bench for adder_frame_accumulator: directed frames plus a random back-to-back
// run, scored against a frame-level arithmetic model. A second instance with a
// 12-bit accumulator shares the stimulus to exercise the overflow flag.
module tb_adder_frame_accumulator;

  localparam int FL = 16;
  localparam int AW = 16;
  localparam int CW = $clog2(FL + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_last;
  logic          out_ready;
  logic [10:0]   in_a;
  logic [10:0]   in_b;

  logic          in_ready;
  logic          out_valid;
  logic          out_overflow;
  logic [AW-1:0] out_sum;
  logic [CW-1:0] out_count;

  logic          in_ready12;
  logic          out_valid12;
  logic          out_overflow12;
  logic [11:0]   out_sum12;
  logic [CW-1:0] out_count12;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int sum;
    int cnt;
    bit ovf;
  } frame_t;

  frame_t exp_q[$];
  int     m_sum;
  int     m_cnt;
  bit     after_close;
  int     idle;
  bit     g;

  adder_frame_accumulator #(.FRAME_LEN(FL), .ACC_W(AW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
    .out_count(out_count), .out_overflow(out_overflow)
  );

  adder_frame_accumulator #(.FRAME_LEN(FL), .ACC_W(12)) dut12 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready12),
    .in_a(in_a), .in_b(in_b), .in_last(in_last),
    .out_valid(out_valid12), .out_ready(out_ready), .out_sum(out_sum12),
    .out_count(out_count12), .out_overflow(out_overflow12)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock: score the current cycle (called at the falling edge), then advance.
  task automatic step(output bit got);
    bit hs;
    got = in_valid && in_ready;
    hs  = out_valid && out_ready;
    check("ready_vs_pending", in_ready, (exp_q.size() == 0));
    if (out_valid) begin
      if (exp_q.size() == 0) begin
        check("spurious_out", out_valid, 0);
      end else begin
        check("sum",   out_sum,      exp_q[0].sum);
        check("count", out_count,    exp_q[0].cnt);
        check("ovf",   out_overflow, exp_q[0].ovf);
        if (hs) void'(exp_q.pop_front());
      end
    end
    if (got) begin
      if (after_close) begin
        check("frame_gap", (idle >= 2), 1);
        after_close = 1'b0;
      end
      m_sum += int'(in_a) + int'(in_b);
      m_cnt++;
      if (in_last || m_cnt == FL) begin
        exp_q.push_back('{sum: m_sum % (1 << AW), cnt: m_cnt, ovf: (m_sum >= (1 << AW))});
        m_sum       = 0;
        m_cnt       = 0;
        after_close = 1'b1;
        idle        = 0;
      end
    end else if (after_close && !in_ready) begin
      idle++;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", out_valid,    0);
    check("rst_out_sum",   out_sum,      0);
    check("rst_out_count", out_count,    0);
    check("rst_out_ovf",   out_overflow, 0);
    check("rst_in_ready",  in_ready,     1);
    rst = 1'b0;
    exp_q.delete();
    m_sum       = 0;
    m_cnt       = 0;
    after_close = 1'b0;
    idle        = 0;
  endtask

  task automatic send(input int a, input int b, input bit last);
    bit got;
    got      = 1'b0;
    in_valid = 1'b1;
    in_a     = 11'(a);
    in_b     = 11'(b);
    in_last  = last;
    for (int i = 0; i < 50; i++) begin
      step(got);
      if (got) break;
    end
    check("send_timeout", got, 1);
    in_valid = 1'b0;
  endtask

  task automatic wait_out();
    bit got;
    for (int i = 0; i < 30; i++) begin
      if (out_valid) break;
      step(got);
    end
    check("wait_out", out_valid, 1);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    in_a      = '0;
    in_b      = '0;
    out_ready = 1'b1;
    @(negedge clk);
    do_reset();

    // Short frame closed by in_last; one-cycle out_valid with out_ready high.
    send(1, 2, 0);
    send(3, 4, 0);
    send(5, 6, 1);
    check("t1_latency_early", out_valid, 0);
    step(g);
    check("t1_valid",  out_valid,    1);
    check("t1_sum",    out_sum,      21);
    check("t1_count",  out_count,    3);
    check("t1_ovf",    out_overflow, 0);
    step(g);
    check("t1_one_cycle", out_valid, 0);
    check("t1_sum_kept",  out_sum,   21);

    // Full-length frame at max operands, then a 5-cycle consumer stall.
    out_ready = 1'b0;
    for (int i = 0; i < FL; i++) send(2047, 2047, 0);
    check("t2_ready_after_full", in_ready, 0);
    wait_out();
    check("t2_sum",   out_sum,      65504);
    check("t2_count", out_count,    16);
    check("t2_ovf",   out_overflow, 0);
    in_valid = 1'b1;
    in_a     = 11'd9;
    in_b     = 11'd9;
    in_last  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step(g);
      check("t2_stall_no_accept", g, 0);
      check("t2_stall_valid", out_valid, 1);
      check("t2_stall_sum", out_sum, 65504);
    end
    out_ready = 1'b1;
    send(9, 9, 1);
    wait_out();
    check("t2_resume_sum",   out_sum,   18);
    check("t2_resume_count", out_count, 1);
    step(g);

    // Carry past 12 bits: 4094 + 2 = 4096.
    send(2047, 2047, 0);
    send(1, 1, 1);
    wait_out();
    check("t3_sum12",   out_sum12,      0);
    check("t3_count12", out_count12,    2);
    check("t3_ovf12",   out_overflow12, 1);
    check("t3_sum16",   out_sum,        4096);
    check("t3_ovf16",   out_overflow,   0);
    step(g);

    // Reset in the middle of a frame discards it.
    send(10, 20, 0);
    send(30, 40, 0);
    do_reset();
    send(7, 8, 1);
    wait_out();
    check("t4_sum",   out_sum,   15);
    check("t4_count", out_count, 1);
    step(g);

    // Back-to-back random frames, input always valid, random consumer.
    in_valid = 1'b1;
    for (int i = 0; i < 800; i++) begin
      in_a      = 11'($urandom_range(0, 2047));
      in_b      = 11'($urandom_range(0, 2047));
      in_last   = ($urandom_range(0, 5) == 0);
      out_ready = 1'($urandom_range(0, 1));
      step(g);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 40; i++) step(g);
    check("t5_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
